// File: rtl/fxp_pkg.sv
// fxp_pkg: definitions shared by the fixed-point blocks.
//   N, Q, ACC_W   : default word width, fractional bits and accumulator width
//   ONE, MAX, MIN : Q4.12 constants (+1.0, most positive, most negative)
//   state_t       : dot-product sequencer FSM states
package fxp_pkg;

    localparam int N     = 16;
    localparam int Q     = 12;
    localparam int ACC_W = 32;

    localparam logic [15:0] ONE = 16'h1000;
    localparam logic [15:0] MAX = 16'h7FFF;
    localparam logic [15:0] MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/multiplier_fixed_point_16_bit.sv
// multiplier_fixed_point_16_bit: combinational signed fixed-point multiplier.
//   a, b : signed QN-Q.Q operands
//   p    : product rescaled to Q fractional bits, saturated to the N-bit range
//   ovf  : the rescaled product did not fit in N bits (p is then clamped)
// A zero operand always gives exactly zero with no overflow.
module multiplier_fixed_point_16_bit #(
    parameter int Q = 12,
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p,
    output logic         ovf
);

    localparam logic signed [2*N-1:0] P_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] P_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [2*N-1:0] full;
    logic signed [2*N-1:0] shifted;

    always_comb begin
        full    = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
        shifted = full >>> Q;
        p       = shifted[N-1:0];
        ovf     = 1'b0;
        if (a == '0 || b == '0) begin
            p = '0;
        end else if (shifted > P_MAX) begin
            p   = P_MAX[N-1:0];
            ovf = 1'b1;
        end else if (shifted < P_MIN) begin
            p   = P_MIN[N-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_point_dot_product_sequencer.sv
// fixed_point_dot_product_sequencer: Q4.12 dot product of two RAM-resident vectors.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, len        : request (accepted only in IDLE) and element count
//   a_base, b_base    : vector base addresses, sampled at start
//   rd_en, a_addr/b_addr : read strobe and addresses to both RAMs
//   a_data, b_data    : read data, valid the cycle after rd_en
//   busy, done        : run in progress / one-cycle completion pulse
//   result            : saturated Q4.12 sum, held until the next accepted start
//   mul_ovf, acc_sat  : sticky product overflow / final sum was clamped
import fxp_pkg::*;

module fixed_point_dot_product_sequencer #(
    parameter int N      = 16,
    parameter int Q      = 12,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [N-1:0]      a_data,
    input  logic [N-1:0]      b_data,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result,
    output logic              mul_ovf,
    output logic              acc_sat
);

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-N){MAX[N-1]}}, MAX};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-N){MIN[N-1]}}, MIN};

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_r, idx;
    logic [ADDR_W-1:0] a_base_r, b_base_r;
    logic              mac_vld;     // read data for a pair is on a_data/b_data
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [N-1:0]      prod;
    logic              prod_ovf;
    logic [N-1:0]      sat_res;
    logic              sat_flag;

    multiplier_fixed_point_16_bit #(.Q(Q), .N(N)) u_mul (
        .a   (a_data),
        .b   (b_data),
        .p   (prod),
        .ovf (prod_ovf)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and control outputs
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (len == '0) ? DONE : RUN;
            RUN: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (idx == len_r - LEN_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are forced to zero outside RUN so the RAM bus idles quietly.
    assign a_addr = rd_en ? a_base_r + ADDR_W'(idx) : '0;
    assign b_addr = rd_en ? b_base_r + ADDR_W'(idx) : '0;

    // Accumulate and clamp; the clamp sees the sum including the final pair
    // so result can be registered as the FSM leaves DRAIN.
    always_comb begin
        acc_nxt  = mac_vld ? acc + {{(ACC_W-N){prod[N-1]}}, prod} : acc;
        sat_res  = acc_nxt[N-1:0];
        sat_flag = 1'b0;
        if ($signed(acc_nxt) > SAT_HI) begin
            sat_res  = MAX;
            sat_flag = 1'b1;
        end else if ($signed(acc_nxt) < SAT_LO) begin
            sat_res  = MIN;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r    <= '0;
            a_base_r <= '0;
            b_base_r <= '0;
            idx      <= '0;
            mac_vld  <= 1'b0;
            acc      <= '0;
            mul_ovf  <= 1'b0;
            result   <= '0;
            acc_sat  <= 1'b0;
        end else begin
            mac_vld <= rd_en;
            if (state == IDLE && start) begin
                len_r    <= len;
                a_base_r <= a_base;
                b_base_r <= b_base;
                idx      <= '0;
                acc      <= '0;
                mul_ovf  <= 1'b0;
                result   <= '0;
                acc_sat  <= 1'b0;
            end else begin
                if (rd_en) idx <= idx + LEN_W'(1);
                if (mac_vld) begin
                    acc     <= acc_nxt;
                    mul_ovf <= mul_ovf | prod_ovf;
                end
                if (state == DRAIN) begin
                    result  <= sat_res;
                    acc_sat <= sat_flag;
                end
            end
        end
    end

endmodule

// File: doc/fixed_point_dot_product_sequencer.md
Name: fixed_point_dot_product_sequencer

Overview:
- Computes a signed Q4.12 dot product of two vectors in external single-port memories (A and B) using one shared 16-bit fixed-point multiplier.
- Issues read addresses, multiplies one element pair per cycle and accumulates in a wide register.
- Returns a saturated Q4.12 result with sticky overflow and saturation flags.
- Sits between the VAE layer controller (start/len/base addresses) and the weight/activation RAMs.

Parameters:
- N, 16, data word width (1 sign bit, 3 integer bits, 12 fractional bits).
- Q, 12, fractional bits.
- ADDR_W, 10, memory address width.
- LEN_W, 8, vector length field width (maximum 255 elements).
- ACC_W, 32, accumulator width, Q12 aligned, sign-extended.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- len  in  LEN_W  element count, sampled when start is accepted.
- a_base  in  ADDR_W  A-vector base address, sampled at start.
- b_base  in  ADDR_W  B-vector base address, sampled at start.
- rd_en  out  1  read strobe to both memories.
- a_addr  out  ADDR_W  A read address.
- b_addr  out  ADDR_W  B read address.
- a_data  in  N  A read data, valid the cycle after rd_en.
- b_data  in  N  B read data, valid the cycle after rd_en.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  N  saturated Q4.12 dot product, held until the next accepted start.
- mul_ovf  out  1  sticky: any product exceeded the Q4.12 range during this run.
- acc_sat  out  1  final accumulator was clamped to produce result.

Behaviour:
- Reset (asynchronous, rst_n=0) forces the following. Outputs: rd_en=0, a_addr=0, b_addr=0, busy=0, done=0, result=0, mul_ovf=0, acc_sat=0. Internal: state=IDLE, accumulator=0.
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE, start=1, len>0:
  - latch len and both base addresses;
  - clear accumulator and mul_ovf;
  - go to RUN.
- IDLE, start=1, len=0:
  - go directly to DONE, with result=0, flags=0 and no rd_en.
- RUN:
  - rd_en=1, a_addr=a_base+i, b_addr=b_base+i, for i=0..len-1, one pair per cycle, no gaps.
  - After issuing i=len-1, go to DRAIN.
- Multiply/accumulate:
  - Each cycle after an rd_en cycle, feed a_data and b_data to the multiplier.
  - Add the sign-extended 16-bit product to the accumulator.
  - OR the multiplier overflow into mul_ovf.
- DRAIN: accumulate the final pair; rd_en=0. Go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - result = accumulator clamped to [0x8000, 0x7FFF], i.e. -8.0 to +7.999755859375.
  - acc_sat=1 if clamped.
  - busy=0.
  - Return to IDLE.
- Latency: start accepted in cycle 0, rd_en in cycles 1..len, done in cycle len+2. For len=0, done is in cycle 1.
- start while busy or in DONE: ignored, with no effect on the current run.
- Address arithmetic wraps modulo 2^ADDR_W, with no error.
- The accumulator cannot overflow for LEN_W≤8 with ACC_W=32 (max |sum| < 2^23 in Q12). No internal wrap check is required.
- The multiplier's zero rule applies: a zero operand yields exactly 0.
- Reset mid-run aborts immediately:
  - all outputs return to reset values;
  - no done pulse is issued for the aborted run.

Decomposition:
- Shared package `fxp_pkg` holds:
  - N, Q and ACC_W defaults;
  - Q12 constants ONE=0x1000, MAX=0x7FFF, MIN=0x8000;
  - the FSM state enum.
- One sub-module: the existing combinational multiplier_fixed_point_16_bit, instantiated once (Q=12, N=16). No other hierarchy.
- Saturation is inline logic in the sequencer.

Test Plan:
- len=1, A[0]=0x1000, B[0]=0x2000, start in cycle 0:
  - rd_en only in cycle 1;
  - done in cycle 3, result=0x2000;
  - mul_ovf=0, acc_sat=0.
- len=4, all A and B elements 0x1000:
  - addresses base..base+3 on consecutive cycles;
  - done in cycle 6, result=0x4000.
- len=2, A=0xF000, 0x0800 and B=0x2000, 0x1000:
  - result = -2.0+0.5 = 0xE800;
  - flags 0.
- len=3, all A=0x7000, all B=0x1000:
  - accumulator 21.0, result=0x7FFF, acc_sat=1.
- len=1, A=0x4000, B=0x4000: mul_ovf=1 at done.
- Control cases:
  - len=0: done in cycle 1, result=0, no rd_en.
  - start asserted during RUN: ignored.
  - rst_n low in the middle of a len=8 run: outputs return to reset values immediately, no done; a following run completes correctly.
